// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid-buffered pipeline register with registered upstream ready and flush.
module pipe_skid_reg #(
  parameter int LENGTH            = 32,
  parameter bit ZERO_WHEN_INVALID = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LENGTH-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [LENGTH-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  input  logic              i_flush,
  output logic [1:0]        o_count
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t            state, state_nxt;
  logic [LENGTH-1:0] main_reg, skid_reg;
  logic              in_fire, out_fire;
  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;
  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end
  // The unused encoding falls back to EMPTY so the FSM always recovers.
  always_comb begin
    state_nxt = i_flush        ? EMPTY :
                (state == EMPTY) ? (in_fire ? ONE : EMPTY) :
                (state == ONE)   ? ((in_fire & ~out_fire) ? TWO :
                                    (~in_fire & out_fire) ? EMPTY : ONE) :
                (state == TWO)   ? (out_fire ? ONE : TWO) : EMPTY;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      main_reg <= '0;
      skid_reg <= '0;
    end else if (!i_flush) begin
      if (in_fire && (state == EMPTY || (state == ONE && out_fire))) main_reg <= i_data;
      else if (state == TWO && out_fire)                                main_reg <= skid_reg;
      if (in_fire && state == ONE && !out_fire) skid_reg <= i_data;
    end
  end
  always_comb begin
    o_valid = (state != EMPTY);
    o_ready = (state != TWO);
    o_count = (state == TWO) ? 2'd2 : (state == ONE) ? 2'd1 : 2'd0;
    o_data  = (ZERO_WHEN_INVALID && !o_valid) ? '0 : main_reg;
  end
endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Two-entry skid-buffered pipeline register. It is the consumer/reader-side counterpart of the plain write-enable stage register.
- Sits between CPU pipeline stages.
- Upstream presents data with valid/ready. Downstream drains with valid/ready.
- Gives full throughput with a registered upstream ready, and supports a pipeline flush.

Parameters:
- LENGTH, 32, data width in bits.
- ZERO_WHEN_INVALID, 1'b0, when 1 o_data is forced to 0 whenever o_valid=0.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- i_data  input  LENGTH  upstream data.
- i_valid  input  1  upstream data valid.
- o_ready  output  1  block can accept upstream data; registered, not combinationally dependent on i_ready.
- o_data  output  LENGTH  downstream data, driven from the main register.
- o_valid  output  1  o_data valid.
- i_ready  input  1  downstream accepts o_data this cycle.
- i_flush  input  1  discard all held entries.
- o_count  output  2  occupancy, 0..2.

Behaviour:
- Definitions: in_fire = i_valid & o_ready; out_fire = o_valid & i_ready.
- State is one of EMPTY, ONE or TWO (2-bit encoding). Storage is main_reg and skid_reg, each LENGTH bits.
- Reset (reset=1 at a rising edge):
  - state goes to EMPTY; main_reg and skid_reg go to 0.
  - Outputs after reset: o_valid=0, o_ready=1, o_data=0, o_count=0.
  - Reset overrides flush and any handshake, including mid-transfer.
- Flush (i_flush=1, reset=0):
  - state goes to EMPTY; both entries are discarded.
  - Any concurrent in_fire is dropped; its data is not stored.
  - Any concurrent out_fire still counts as consumed downstream. Data registers may keep stale values.
- Output decode:
  - o_valid = (state != EMPTY).
  - o_ready = (state != TWO).
  - o_count = 0, 1 or 2 for EMPTY, ONE or TWO.
- Transitions, with no flush and no reset:
  - EMPTY: in_fire -> ONE, main_reg<=i_data. Otherwise stay EMPTY.
  - ONE, in_fire & out_fire: stay ONE, main_reg<=i_data.
  - ONE, in_fire only: go to TWO, skid_reg<=i_data; main_reg holds.
  - ONE, out_fire only: go to EMPTY.
  - ONE, neither: hold.
  - TWO: out_fire -> ONE, main_reg<=skid_reg. in_fire cannot occur (o_ready=0). Otherwise hold.
- Ordering: FIFO. Data leaves in acceptance order; none are duplicated or lost except on flush or reset.
- Latency: an accepted word appears on o_data/o_valid the cycle after acceptance when the block was EMPTY.
- Throughput: one word per cycle sustained when i_valid=i_ready=1.
- Stall behaviour:
  - o_data and o_valid are stable while o_valid=1 and i_ready=0.
  - o_ready falls only on the edge where the second entry is captured, so one extra word is absorbed after downstream stalls.
- ZERO_WHEN_INVALID=1: o_data = o_valid ? main_reg : 0. When 0, o_data = main_reg always.
- i_valid while o_ready=0 has no effect. Upstream must hold i_data/i_valid until accepted; the bench checks this but the block does not enforce it.

Test Plan:
- Reset, then i_valid=1 with i_data=0xA5A5_0001, i_ready=1 -> next cycle o_valid=1, o_data=0xA5A5_0001, o_count=1. Following cycle o_valid=0, o_count=0.
- Stream 0x10..0x17 with i_valid=i_ready=1 every cycle -> o_data=0x10..0x17 on consecutive cycles, o_ready constantly 1, o_count=1 throughout.
- Hold i_ready=0 while sending 0x20,0x21,0x22:
  - 0x20 and 0x21 are accepted, then o_ready=0 and o_count=2, and 0x22 is held upstream.
  - Raise i_ready: outputs 0x20, 0x21, 0x22 in order. o_ready returns to 1 the cycle after the first drain.
- In TWO (holding 0x30,0x31), assert i_flush together with i_valid=1 carrying 0x32 -> next cycle o_valid=0, o_count=0, o_ready=1. 0x32 is never output.
- Assert reset in state TWO with i_valid=1 and i_flush=1 -> next cycle o_valid=0, o_ready=1, o_count=0, and o_data=0 for ZERO_WHEN_INVALID=0 as well.
- ZERO_WHEN_INVALID=1 with LENGTH=8: accept 0xFF then drain -> o_data=0xFF while valid, and 0x00 the cycle o_valid falls.
